surfboard_seq: RTL and testbench

- Sequential, parametrised NxN matrix multiplier: C = A×B, or C = A×B + C_prev when accumulation is requested.
- One multiplier is time-shared over N³ cycles.
- Operands enter through a valid/ready handshake. The result is held behind its own valid/ready handshake.
- Used where a fully combinational N³-multiplier array is too large, and where results must accumulate across successive operand pairs.

---
 rtl/surfboard_seq.sv | 131 +++++++++++++
 tb/tb_surfboard_seq.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/surfboard_seq.sv
// rtl/surfboard_seq.sv - sequential NxN matrix multiply-accumulate over one shared multiplier
// C = A*B (or C + A*B) computed one multiply-add per cycle, k innermost, then j, then i.
module surfboard_seq #(
   parameter int N      = 3,
   parameter int W      = 2,
   parameter int OW     = 6,
   parameter int SIGNED = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic                        acc_en,
   input  logic [0:N*N-1][W-1:0]       A,
   input  logic [0:N*N-1][W-1:0]       B,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [0:N*N-1][OW-1:0]      C,
   output logic                        busy
);

   localparam int CW = $clog2(N);
   localparam int IW = $clog2(N*N);
   // Multiply wide enough that the low OW bits equal the extended/truncated 2W-bit product.
   localparam int EW = (OW > 2*W) ? OW : 2*W;
   localparam logic [CW-1:0] LAST = CW'(N-1);
   localparam logic SX = (SIGNED != 0);

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

   state_t                   state;
   logic [0:N*N-1][W-1:0]    a_q;
   logic [0:N*N-1][W-1:0]    b_q;
   logic                     acc_en_q;
   logic [CW-1:0]            i;
   logic [CW-1:0]            j;
   logic [CW-1:0]            k;
   logic [OW-1:0]            acc;

   logic [IW-1:0]            a_idx;
   logic [IW-1:0]            b_idx;
   logic [IW-1:0]            c_idx;
   logic [W-1:0]             a_el;
   logic [W-1:0]             b_el;
   logic [EW-1:0]            a_ext;
   logic [EW-1:0]            b_ext;
   logic [EW-1:0]            prod;
   logic [OW-1:0]            base;
   logic [OW-1:0]            sum;

   always_comb begin
      a_idx = IW'(i) * IW'(N) + IW'(k);
      b_idx = IW'(k) * IW'(N) + IW'(j);
      c_idx = IW'(i) * IW'(N) + IW'(j);
      a_el  = a_q[a_idx];
      b_el  = b_q[b_idx];
      a_ext = {{(EW-W){a_el[W-1] & SX}}, a_el};
      b_ext = {{(EW-W){b_el[W-1] & SX}}, b_el};
      prod  = a_ext * b_ext;
      // First term of each element seeds from the held C when accumulating.
      if (k == '0)
         base = acc_en_q ? C[c_idx] : '0;
      else
         base = acc;
      sum = base + prod[OW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         C         <= '0;
         a_q       <= '0;
         b_q       <= '0;
         acc_en_q  <= 1'b0;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         acc       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= A;
                  b_q      <= B;
                  acc_en_q <= acc_en;
                  i        <= '0;
                  j        <= '0;
                  k        <= '0;
                  state    <= COMPUTE;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            COMPUTE: begin
               if (k == LAST) begin
                  C[c_idx] <= sum;
                  k        <= '0;
                  if (j == LAST) begin
                     j <= '0;
                     if (i == LAST) begin
                        i         <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                     end else begin
                        i <= i + 1'b1;
                     end
                  end else begin
                     j <= j + 1'b1;
                  end
               end else begin
                  acc <= sum;
                  k   <= k + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_surfboard_seq.sv
// tb/tb_surfboard_seq.sv - randomized self-checking bench for surfboard_seq
// Three configurations share one stimulus: signed OW=6, unsigned OW=6, unsigned OW=4.
module tb_surfboard_seq;

   logic clk, rst, in_valid, acc_en, out_ready;
   logic [0:8][1:0] A, B;
   logic in_ready0, in_ready1, in_ready2;
   logic out_valid0, out_valid1, out_valid2;
   logic busy0, busy1, busy2;
   logic [0:8][5:0] C0, C1;
   logic [0:8][3:0] C2;

   int checks = 0;
   int errors = 0;
   int exp0[9], exp1[9], exp2[9];

   surfboard_seq #(.N(3), .W(2), .OW(6), .SIGNED(1)) d0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .acc_en(acc_en),
      .A(A), .B(B), .out_valid(out_valid0), .out_ready(out_ready), .C(C0), .busy(busy0));
   surfboard_seq #(.N(3), .W(2), .OW(6), .SIGNED(0)) d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .acc_en(acc_en),
      .A(A), .B(B), .out_valid(out_valid1), .out_ready(out_ready), .C(C1), .busy(busy1));
   surfboard_seq #(.N(3), .W(2), .OW(4), .SIGNED(0)) d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .acc_en(acc_en),
      .A(A), .B(B), .out_valid(out_valid2), .out_ready(out_ready), .C(C2), .busy(busy2));

   always #5 clk = ~clk;

   function automatic int sval(input logic [1:0] x, input bit sgn);
      return (sgn && x[1]) ? int'(x) - 4 : int'(x);
   endfunction

   // Reference: plain integer matrix product, then reduce modulo 2^OW.
   task automatic model_op(input logic [0:8][1:0] a, input logic [0:8][1:0] b, input bit acc);
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            int ss, su;
            ss = 0;
            su = 0;
            for (int m = 0; m < 3; m++) begin
               ss += sval(a[r*3+m], 1'b1) * sval(b[m*3+c], 1'b1);
               su += sval(a[r*3+m], 1'b0) * sval(b[m*3+c], 1'b0);
            end
            exp0[r*3+c] = ((acc ? exp0[r*3+c] : 0) + ss) & 63;
            exp1[r*3+c] = ((acc ? exp1[r*3+c] : 0) + su) & 63;
            exp2[r*3+c] = ((acc ? exp2[r*3+c] : 0) + su) & 15;
         end
      end
   endtask

   task automatic start_op(input logic [0:8][1:0] a, input logic [0:8][1:0] b, input bit acc);
      int cnt;
      cnt = 0;
      while (in_ready0 !== 1'b1 && cnt < 100) begin
         @(posedge clk); #1;
         cnt++;
      end
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL start_ready: in_ready=%b required 1", in_ready0);
      end
      A = a;
      B = b;
      acc_en = acc;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      A = 18'($urandom);
      B = 18'($urandom);
      acc_en = 1'($urandom);
      model_op(a, b, acc);
      checks++;
      if (busy0 !== 1'b1 || in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin
         errors++;
         $display("FAIL compute_flags: busy=%b in_ready=%b out_valid=%b required 1 0 0",
                  busy0, in_ready0, out_valid0);
      end
      cnt = 0;
      while (out_valid0 !== 1'b1 && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      checks++;
      if (cnt != 27) begin
         errors++;
         $display("FAIL latency: %0d edges required 27", cnt);
      end
      checks++;
      if (out_valid1 !== 1'b1 || out_valid2 !== 1'b1 || busy0 !== 1'b0 || in_ready0 !== 1'b0) begin
         errors++;
         $display("FAIL done_flags: ov1=%b ov2=%b busy=%b in_ready=%b required 1 1 0 0",
                  out_valid1, out_valid2, busy0, in_ready0);
      end
      for (int e = 0; e < 9; e++) begin
         checks++;
         if (C0[e] !== 6'(exp0[e]) || C1[e] !== 6'(exp1[e]) || C2[e] !== 4'(exp2[e])) begin
            errors++;
            $display("FAIL result[%0d]: C=%0h/%0h/%0h required %0h/%0h/%0h",
                     e, C0[e], C1[e], C2[e], exp0[e], exp1[e], exp2[e]);
         end
      end
   endtask

   task automatic finish_op(input int stall);
      for (int s = 0; s < stall; s++) begin
         out_ready = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (out_valid0 !== 1'b1 || C0 !== {6'(exp0[0]), 6'(exp0[1]), 6'(exp0[2]), 6'(exp0[3]),
             6'(exp0[4]), 6'(exp0[5]), 6'(exp0[6]), 6'(exp0[7]), 6'(exp0[8])}) begin
            errors++;
            $display("FAIL stall_hold: out_valid=%b C=%h", out_valid0, C0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || out_valid2 !== 1'b0 || in_ready2 !== 1'b1) begin
         errors++;
         $display("FAIL out_handshake: out_valid=%b in_ready=%b required 0 1", out_valid0, in_ready0);
      end
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0 || busy0 !== 1'b0 || C0 !== '0 || C1 !== '0 || C2 !== '0) begin
         errors++;
         $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b C0=%h", in_ready0, out_valid0, busy0, C0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int e = 0; e < 9; e++) begin
         exp0[e] = 0;
         exp1[e] = 0;
         exp2[e] = 0;
      end
   endtask

   task automatic test_identity;
      logic [0:8][1:0] a, b;
      for (int e = 0; e < 9; e++) begin
         a[e] = (e % 4 == 0) ? 2'b01 : 2'b00;
         b[e] = 2'b11;
      end
      start_op(a, b, 1'b0);
      for (int e = 0; e < 9; e++) begin
         checks++;
         if (C0[e] !== 6'h3F || C1[e] !== 6'd3) begin
            errors++;
            $display("FAIL identity[%0d]: signed=%0h unsigned=%0h required 3f 3", e, C0[e], C1[e]);
         end
      end
      finish_op(0);
   endtask

   task automatic test_signed_acc;
      logic [0:8][1:0] a;
      for (int e = 0; e < 9; e++) a[e] = 2'b10;
      start_op(a, a, 1'b0);
      checks++;
      if (C0 !== {9{6'd12}}) begin
         errors++;
         $display("FAIL signed_prod: C=%h required all 0c", C0);
      end
      finish_op(1);
      start_op(a, a, 1'b1);
      checks++;
      if (C0 !== {9{6'd24}}) begin
         errors++;
         $display("FAIL signed_acc: C=%h required all 18", C0);
      end
      finish_op(0);
   endtask

   task automatic test_wrap;
      logic [0:8][1:0] a;
      for (int e = 0; e < 9; e++) a[e] = 2'b11;
      start_op(a, a, 1'b0);
      checks++;
      if (C2 !== {9{4'd11}}) begin
         errors++;
         $display("FAIL wrap: C=%h required all b", C2);
      end
      finish_op(0);
   endtask

   task automatic test_backpressure;
      logic [0:8][5:0] held;
      start_op(18'($urandom), 18'($urandom), 1'b0);
      held = C0;
      for (int s = 0; s < 10; s++) begin
         in_valid = 1'b1;
         A = 18'($urandom);
         B = 18'($urandom);
         acc_en = 1'($urandom);
         out_ready = 1'b0;
         @(posedge clk); #1;
         checks++;
         if (C0 !== held || in_ready0 !== 1'b0 || out_valid0 !== 1'b1) begin
            errors++;
            $display("FAIL backpressure: C=%h in_ready=%b out_valid=%b required C=%h 0 1",
                     C0, in_ready0, out_valid0, held);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || C0 !== held) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b in_ready=%b C=%h required 0 1 %h",
                  out_valid0, in_ready0, C0, held);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (busy0 !== 1'b0 || C0 !== held) begin
         errors++;
         $display("FAIL no_capture: busy=%b C=%h required 0 %h", busy0, C0, held);
      end
      start_op(18'($urandom), 18'($urandom), 1'b1);
      finish_op(2);
   endtask

   task automatic test_reset_mid;
      A = 18'($urandom);
      B = 18'($urandom);
      acc_en = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b1 ||
          C0 !== '0 || C1 !== '0 || C2 !== '0) begin
         errors++;
         $display("FAIL reset_mid: out_valid=%b busy=%b in_ready=%b C0=%h C2=%h",
                  out_valid0, busy0, in_ready0, C0, C2);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int e = 0; e < 9; e++) begin
         exp0[e] = 0;
         exp1[e] = 0;
         exp2[e] = 0;
      end
      checks++;
      if (in_ready0 !== 1'b1) begin
         errors++;
         $display("FAIL reset_release: in_ready=%b required 1", in_ready0);
      end
      start_op(18'($urandom), 18'($urandom), 1'b1);
      finish_op(0);
   endtask

   task automatic test_random;
      for (int n = 0; n < 20; n++) begin
         start_op(18'($urandom), 18'($urandom), 1'($urandom));
         finish_op(int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_back_to_back;
      for (int n = 0; n < 4; n++) begin
         start_op(18'($urandom), 18'($urandom), 1'b1);
         finish_op(0);
      end
   endtask

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      in_valid = 1'b0;
      acc_en = 1'b0;
      out_ready = 1'b0;
      A = '0;
      B = '0;
      test_reset;
      test_identity;
      test_signed_acc;
      test_wrap;
      test_backpressure;
      test_random;
      test_reset_mid;
      test_back_to_back;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
